// File: rtl/f1_timer_pkg.sv
// f1_timer_pkg: shared state encoding, LFSR constants and light-bar constants
package f1_timer_pkg;
    typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, TIMING, DONE, FAULT} state_e;
    localparam int LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;
    localparam logic [7:0] LIGHTS_OFF = 8'h00;
    localparam logic [7:0] LIGHTS_FULL = 8'hFF;
endpackage

// File: rtl/f1_reaction_timer_lfsr7.sv
// lfsr7: free-running 7-bit Fibonacci LFSR (x^7+x^6+1), never reaches zero
//   clk : clock
//   rst : synchronous active-high reset, loads the seed
//   q   : current LFSR value, advances every clock
module lfsr7
    import f1_timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= LFSR_SEED;
        else     q <= {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    end
endmodule

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: start-light countdown, random hold, reaction timing and jump-start detection
//   clk, rst   : clock, synchronous active-high reset
//   tick       : one-cycle timebase pulse
//   trigger    : start request level, rising edge starts a sequence
//   react      : driver button level, rising edge stops timing
//   lights     : light bar, bit0 is the first light
//   rtime      : reaction time in ticks (saturating)
//   valid      : rtime holds a finished measurement
//   jump_start : button pressed before lights-out
//   busy       : sequence in progress
module f1_reaction_timer
    import f1_timer_pkg::*;
#(
    parameter int LIGHT_TICKS = 16,
    parameter int MIN_HOLD    = 8,
    parameter int RT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic                react,
    output logic [7:0]          lights,
    output logic [RT_WIDTH-1:0] rtime,
    output logic                valid,
    output logic                jump_start,
    output logic                busy
);
    localparam logic [15:0]         LT_LAST = 16'(LIGHT_TICKS - 1);
    localparam logic [15:0]         HOLD_MIN = 16'(MIN_HOLD);
    localparam logic [RT_WIDTH-1:0] RT_MAX = '1;
    localparam logic [RT_WIDTH-1:0] RT_ONE = RT_WIDTH'(1);

    logic              trigger_q, react_q, trig_e, react_e;
    logic [LFSR_W-1:0] lfsr;
    state_e            state_q, state_d;
    logic [7:0]        lights_q, lights_d;
    logic [15:0]       cnt_q, cnt_d, hold_q, hold_d;
    logic [RT_WIDTH-1:0] rtime_q, rtime_d;
    logic              valid_q, valid_d, jump_q, jump_d;

    lfsr7 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign trig_e  = trigger & ~trigger_q;
    assign react_e = react & ~react_q;

    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        rtime_d  = rtime_q;
        valid_d  = valid_q;
        jump_d   = jump_q;
        case (state_q)
            IDLE, DONE, FAULT: begin
                if (trig_e) begin
                    state_d  = LIGHTS;
                    lights_d = 8'h01;
                    cnt_d    = '0;
                    rtime_d  = '0;
                    valid_d  = 1'b0;
                    jump_d   = 1'b0;
                end
            end
            LIGHTS, HOLD: begin
                // a press before lights-out wins over any tick on the same cycle
                if (react_e) begin
                    state_d  = FAULT;
                    lights_d = LIGHTS_OFF;
                    jump_d   = 1'b1;
                    valid_d  = 1'b0;
                end else if (tick) begin
                    if (state_q == LIGHTS) begin
                        if (cnt_q == LT_LAST) begin
                            lights_d = {lights_q[6:0], 1'b1};
                            cnt_d    = '0;
                            // the shift that completes the bar also starts the random hold
                            if (lights_q[6:0] == LIGHTS_FULL[6:0]) begin
                                state_d = HOLD;
                                hold_d  = 16'(lfsr) + HOLD_MIN;
                            end
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end else if (hold_q == 16'd1) begin
                        state_d  = TIMING;
                        lights_d = LIGHTS_OFF;
                        rtime_d  = '0;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
            end
            TIMING: begin
                if (react_e) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else if (tick && rtime_q != RT_MAX) begin
                    rtime_d = rtime_q + RT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lights_q  <= LIGHTS_OFF;
            cnt_q     <= '0;
            hold_q    <= '0;
            rtime_q   <= '0;
            valid_q   <= 1'b0;
            jump_q    <= 1'b0;
            trigger_q <= 1'b0;
            react_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lights_q  <= lights_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            rtime_q   <= rtime_d;
            valid_q   <= valid_d;
            jump_q    <= jump_d;
            trigger_q <= trigger;
            react_q   <= react;
        end
    end

    assign lights     = lights_q;
    assign rtime      = rtime_q;
    assign valid      = valid_q;
    assign jump_start = jump_q;
    assign busy       = (state_q == LIGHTS) || (state_q == HOLD) || (state_q == TIMING);
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: table vectors, directed corner sequences and random stimulus against a tick-count model
module tb_f1_reaction_timer;
    localparam int LT = 2;
    localparam int MH = 2;
    localparam int RW = 4;
    localparam int RMAX = 15;
    localparam int FULL_T = 7 * LT;

    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, trigger = 1'b0, react = 1'b0;
    logic [7:0] lights;
    logic [RW-1:0] rtime;
    logic valid, jump_start, busy;

    int checks = 0;
    int errors = 0;

    f1_reaction_timer #(.LIGHT_TICKS(LT), .MIN_HOLD(MH), .RT_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
        .lights(lights), .rtime(rtime), .valid(valid), .jump_start(jump_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // model: a run is described by ticks elapsed since its start; lights-out
    // happens at FULL_T + hold ticks, hold drawn from the LFSR when the bar fills
    bit m_run, m_valid, m_jump, m_te, m_re, m_tq, m_rq;
    int m_t, m_hold, m_rt;
    logic [6:0] m_lfsr;

    always @(posedge clk) begin
        m_te = trigger & !m_tq;
        m_re = react & !m_rq;
        if (rst) begin
            m_run = 0; m_t = 0; m_hold = 0; m_rt = 0; m_valid = 0; m_jump = 0;
            m_lfsr = 7'h01; m_tq = 0; m_rq = 0;
        end else begin
            if (!m_run) begin
                if (m_te) begin
                    m_run = 1; m_t = 0; m_hold = 0; m_rt = 0; m_valid = 0; m_jump = 0;
                end
            end else if (m_re) begin
                m_run = 0;
                if (m_t >= FULL_T && m_t >= FULL_T + m_hold) begin
                    m_valid = 1;
                    m_rt = (m_t - FULL_T - m_hold > RMAX) ? RMAX : m_t - FULL_T - m_hold;
                end else m_jump = 1;
            end else if (tick) begin
                m_t++;
                if (m_t == FULL_T) m_hold = int'(m_lfsr) + MH;
            end
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            m_tq = trigger;
            m_rq = react;
        end
    end

    function automatic int exp_lights();
        if (!m_run) return 0;
        if (m_t < FULL_T) return (1 << (m_t / LT + 1)) - 1;
        if (m_t < FULL_T + m_hold) return 255;
        return 0;
    endfunction

    function automatic int exp_rtime();
        if (!m_run) return m_rt;
        if (m_t >= FULL_T && m_t >= FULL_T + m_hold)
            return (m_t - FULL_T - m_hold > RMAX) ? RMAX : m_t - FULL_T - m_hold;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic tk, input logic tg, input logic rc);
        @(negedge clk);
        rst = r; tick = tk; trigger = tg; react = rc;
        @(posedge clk);
        #1;
        chk("model_lights", int'(lights), exp_lights());
        chk("model_rtime", int'(rtime), exp_rtime());
        chk("model_valid", int'(valid), int'(m_valid));
        chk("model_jump", int'(jump_start), int'(m_jump));
        chk("model_busy", int'(busy), int'(m_run));
    endtask

    task automatic run_to_out(input logic tg, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 600; i++) begin
            step(0, 1, tg, 0);
            if (busy && lights == 8'h00) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) chk("lights_out_timeout", 0, 1);
    endtask

    task automatic run_to_full(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            step(0, 1, 0, 0);
            if (lights == 8'hFF) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) chk("full_bar_timeout", 0, 1);
    endtask

    typedef struct {
        logic r, tk, tg, rc;
        logic [7:0] l;
        logic [3:0] rt;
        logic v, j, b;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int n;
        tbl[0]  = '{1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 8'h01, 4'd0, 0, 0, 1};
        tbl[2]  = '{0, 1, 1, 0, 8'h01, 4'd0, 0, 0, 1};
        tbl[3]  = '{0, 1, 1, 0, 8'h03, 4'd0, 0, 0, 1};
        tbl[4]  = '{0, 1, 1, 0, 8'h03, 4'd0, 0, 0, 1};
        tbl[5]  = '{0, 1, 1, 0, 8'h07, 4'd0, 0, 0, 1};
        tbl[6]  = '{0, 1, 1, 1, 8'h00, 4'd0, 0, 1, 0};
        tbl[7]  = '{0, 1, 1, 0, 8'h00, 4'd0, 0, 1, 0};
        tbl[8]  = '{0, 1, 1, 1, 8'h00, 4'd0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 8'h00, 4'd0, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 8'h01, 4'd0, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].tk, tbl[i].tg, tbl[i].rc);
            chk($sformatf("vec%0d_lights", i), int'(lights), int'(tbl[i].l));
            chk($sformatf("vec%0d_rtime", i), int'(rtime), int'(tbl[i].rt));
            chk($sformatf("vec%0d_valid", i), int'(valid), int'(tbl[i].v));
            chk($sformatf("vec%0d_jump", i), int'(jump_start), int'(tbl[i].j));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].b));
        end

        // normal run: react five ticks after lights-out
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("normal_first_light", int'(lights), 1);
        step(0, 0, 0, 0);
        run_to_out(0, n);
        chk("normal_out_time", n, FULL_T + m_hold);
        repeat (5) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("normal_rtime", int'(rtime), 5);
        chk("normal_valid", int'(valid), 1);
        chk("normal_jump", int'(jump_start), 0);
        chk("normal_busy", int'(busy), 0);

        // trigger and react edges together in DONE: restart, react ignored
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        chk("retrig_lights", int'(lights), 1);
        chk("retrig_valid", int'(valid), 0);
        chk("retrig_busy", int'(busy), 1);

        // trigger held through the whole run; react coincides with a tick at rtime=3
        run_to_out(1, n);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("simul_pre_rtime", int'(rtime), 3);
        step(0, 1, 1, 1);
        chk("simul_rtime", int'(rtime), 3);
        chk("simul_valid", int'(valid), 1);
        repeat (3) step(0, 1, 1, 0);
        chk("held_trigger_busy", int'(busy), 0);
        chk("held_trigger_valid", int'(valid), 1);

        // saturation of the 4-bit counter
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        run_to_out(0, n);
        repeat (20) step(0, 1, 0, 0);
        chk("sat_rtime", int'(rtime), 15);
        chk("sat_busy", int'(busy), 1);
        step(0, 0, 0, 1);
        chk("sat_final_rtime", int'(rtime), 15);
        chk("sat_final_valid", int'(valid), 1);

        // trigger pulse in HOLD ignored, then react on the final hold tick
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        run_to_full(n);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("hold_pulse_lights", int'(lights), 255);
        chk("hold_pulse_busy", int'(busy), 1);
        repeat (m_hold - 1) step(0, 1, 0, 0);
        chk("hold_last_lights", int'(lights), 255);
        step(0, 1, 0, 1);
        chk("hold_react_jump", int'(jump_start), 1);
        chk("hold_react_lights", int'(lights), 0);
        chk("hold_react_valid", int'(valid), 0);
        chk("hold_react_busy", int'(busy), 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("fault_react_jump", int'(jump_start), 1);
        chk("fault_react_busy", int'(busy), 0);

        // reset in TIMING with rtime=9, then a clean run
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        run_to_out(0, n);
        repeat (9) step(0, 1, 0, 0);
        chk("mid_rtime", int'(rtime), 9);
        step(1, 1, 0, 0);
        chk("mid_rst_lights", int'(lights), 0);
        chk("mid_rst_rtime", int'(rtime), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_jump", int'(jump_start), 0);
        chk("mid_rst_busy", int'(busy), 0);
        step(0, 0, 1, 0);
        chk("post_rst_lights", int'(lights), 1);
        run_to_out(0, n);
        repeat (2) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("post_rst_rtime", int'(rtime), 2);
        chk("post_rst_valid", int'(valid), 1);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 800) == 0, $urandom % 2,
                 (($urandom % 30) == 0) ? ~trigger : trigger,
                 (($urandom % 50) == 0) ? ~react : react);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
